dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM plus a small MMIO register window
// (timer, compare, sticky status, GPIO, control) on a single-cycle store port.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  input  logic [2:0]  funct3,
  output logic [31:0] readdata,
  output logic [7:0]  gpio_o,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] SEL_TIMER   = 3'd0;
  localparam logic [2:0] SEL_TIMECMP = 3'd1;
  localparam logic [2:0] SEL_STATUS  = 3'd2;
  localparam logic [2:0] SEL_GPIO    = 3'd3;
  localparam logic [2:0] SEL_CTRL    = 3'd4;

  // Store port contract: there is no handshake. When memwrite is 1 at a rising
  // edge the store described by addr/writedata/funct3 commits at that edge;
  // readdata is a pure combinational function of addr and pre-edge state.

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] timer, timecmp;
  logic        st_match, st_err;
  logic [7:0]  gpio;
  logic        tmr_en, irq_en;

  logic [AW-1:0] ram_idx;
  logic [2:0]    reg_sel;
  logic          ram_hit, mmio_hit;

  assign ram_idx  = addr[AW+1:2];
  assign reg_sel  = addr[4:2];
  assign ram_hit  = (addr[31:AW+2] == '0);
  assign mmio_hit = (addr[31:5] == MMIO_BASE[31:5]);

  // ---------------------------------------------------------------- store decode
  logic       store_en, size_ok, misaligned, bad_store;
  logic       store_err, ram_we, mmio_we;
  logic [3:0] byte_en;
  logic [31:0] lane_data;

  always_comb begin
    store_en   = rst_n && memwrite;
    size_ok    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    misaligned = ((funct3 == 3'b001) && addr[0]) ||
                 ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    // MMIO registers are word-only; sub-word stores there are errors.
    bad_store  = !size_ok || misaligned || (mmio_hit && (funct3 != 3'b010));
    // Stores to unmapped space are dropped without raising an error.
    store_err  = store_en && (ram_hit || mmio_hit) && bad_store;
    ram_we     = store_en && ram_hit && !bad_store;
    mmio_we    = store_en && mmio_hit && !bad_store;

    byte_en   = 4'b0000;
    lane_data = writedata;
    case (funct3)
      3'b000: begin
        byte_en   = 4'b0001 << addr[1:0];
        lane_data = {4{writedata[7:0]}};
      end
      3'b001: begin
        byte_en   = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{writedata[15:0]}};
      end
      3'b010: begin
        byte_en   = 4'b1111;
        lane_data = writedata;
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = writedata;
      end
    endcase
  end

  // RAM is deliberately not reset; store_en already blocks writes during reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && byte_en[i]) begin
        mem[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- registers
  logic [31:0] timer_nxt, timecmp_nxt;
  logic        match_nxt, err_nxt;
  logic [7:0]  gpio_nxt;
  logic        tmr_en_nxt, irq_en_nxt;
  logic        match_set;
  logic [1:0]  status_clr;

  always_comb begin
    timer_nxt   = tmr_en ? (timer + 32'd1) : timer;
    timecmp_nxt = timecmp;
    gpio_nxt    = gpio;
    tmr_en_nxt  = tmr_en;
    irq_en_nxt  = irq_en;
    status_clr  = 2'b00;
    match_set   = tmr_en && (timer == timecmp);

    if (mmio_we) begin
      case (reg_sel)
        SEL_TIMER:   timer_nxt   = writedata;
        SEL_TIMECMP: timecmp_nxt = writedata;
        SEL_STATUS:  status_clr  = writedata[1:0];
        SEL_GPIO:    gpio_nxt    = writedata[7:0];
        SEL_CTRL: begin
          tmr_en_nxt = writedata[0];
          irq_en_nxt = writedata[1];
        end
        default: ;
      endcase
    end

    // A set event in the same cycle as a write-1-to-clear wins.
    match_nxt = (st_match & ~status_clr[0]) | match_set;
    err_nxt   = (st_err   & ~status_clr[1]) | store_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer    <= 32'h0000_0000;
      timecmp  <= 32'hFFFF_FFFF;
      st_match <= 1'b0;
      st_err   <= 1'b0;
      gpio     <= 8'h00;
      tmr_en   <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      timer    <= timer_nxt;
      timecmp  <= timecmp_nxt;
      st_match <= match_nxt;
      st_err   <= err_nxt;
      gpio     <= gpio_nxt;
      tmr_en   <= tmr_en_nxt;
      irq_en   <= irq_en_nxt;
    end
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    readdata = 32'h0000_0000;
    if (ram_hit) begin
      readdata = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        SEL_TIMER:   readdata = timer;
        SEL_TIMECMP: readdata = timecmp;
        SEL_STATUS:  readdata = {30'd0, st_err, st_match};
        SEL_GPIO:    readdata = {24'd0, gpio};
        SEL_CTRL:    readdata = {30'd0, irq_en, tmr_en};
        default:     readdata = 32'h0000_0000;
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign gpio_o = rst_n ? gpio : 8'h00;
  assign irq_o  = rst_n && st_match && irq_en;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written timer/reset
// sequences, then randomized traffic against a byte-level reference model.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] A_TMR = BASE + 32'h00;
  localparam logic [31:0] A_CMP = BASE + 32'h04;
  localparam logic [31:0] A_STS = BASE + 32'h08;
  localparam logic [31:0] A_GPO = BASE + 32'h0C;
  localparam logic [31:0] A_CTL = BASE + 32'h10;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        memwrite = 1'b0;
  logic [31:0] writedata = '0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] readdata;
  logic [7:0]  gpio_o;
  logic        irq_o;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .memwrite(memwrite),
    .writedata(writedata), .funct3(funct3), .readdata(readdata),
    .gpio_o(gpio_o), .irq_o(irq_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [7:0]  mb [0:4*DEPTH-1];
  logic [31:0] m_timer, m_cmp;
  logic        m_match, m_err, m_tmr_en, m_irq_en;
  logic [7:0]  m_gpio;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    if (a < 4 * DEPTH) begin
      w = a & ~32'd3;
      return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    end
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:0] & 5'h1C)
      5'h00:   return m_timer;
      5'h04:   return m_cmp;
      5'h08:   return {30'd0, m_err, m_match};
      5'h0C:   return {24'd0, m_gpio};
      5'h10:   return {30'd0, m_irq_en, m_tmr_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic [2:0] f3);
    int          nbytes;
    logic        in_ram, in_mmio, set_match, set_err;
    logic [1:0]  clr;
    logic [31:0] t_next;
    if (!r) begin
      m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_err = 0;
      m_gpio = 0; m_tmr_en = 0; m_irq_en = 0;
      return;
    end
    nbytes    = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    in_ram    = (a < 4 * DEPTH);
    in_mmio   = (a[31:5] == BASE[31:5]);
    t_next    = m_tmr_en ? m_timer + 1 : m_timer;
    set_match = m_tmr_en && (m_timer == m_cmp);
    set_err   = 0;
    clr       = 0;
    if (we && (in_ram || in_mmio)) begin
      if (nbytes == 0 || (a % nbytes) != 0) set_err = 1;
      else if (in_ram) begin
        for (int i = 0; i < nbytes; i++) mb[a + i] = wd[8*i +: 8];
      end else if (nbytes != 4) set_err = 1;
      else begin
        case (a[4:0])
          5'h00: t_next = wd;
          5'h04: m_cmp = wd;
          5'h08: clr = wd[1:0];
          5'h0C: m_gpio = wd[7:0];
          5'h10: begin m_tmr_en = wd[0]; m_irq_en = wd[1]; end
          default: ;
        endcase
      end
    end
    m_timer = t_next;
    m_match = (m_match & ~clr[0]) | set_match;
    m_err   = (m_err & ~clr[1]) | set_err;
  endtask

  // ---------------------------------------------------------------- driver
  logic [31:0] act_rd, exp_rd;
  logic [7:0]  act_gpio, exp_gpio;
  logic        act_irq, exp_irq;

  // One cycle: drive at the falling edge, sample 1ns later, then advance the model.
  task automatic cyc(input logic r, input logic [31:0] a, input logic we,
                     input logic [31:0] wd, input logic [2:0] f3);
    @(negedge clk);
    rst_n = r; addr = a; memwrite = we; writedata = wd; funct3 = f3;
    #1;
    act_rd = readdata; act_gpio = gpio_o; act_irq = irq_o;
    exp_rd   = model_read(a);
    exp_gpio = r ? m_gpio : 8'h00;
    exp_irq  = r && m_match && m_irq_en;
    model_step(r, a, we, wd, f3);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, a, 1'b0, 32'd0, 3'b010);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] wd);
    cyc(1'b1, a, 1'b1, wd, 3'b010);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] e_rd;
    logic [7:0]  e_gpio;
  } vec_t;

  vec_t vecs [28];

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf3;
    logic        rwe, rr;

    vecs[0]  = '{A_CMP,          0, 32'h0,        3'b010, 32'hFFFF_FFFF, 8'h00};
    vecs[1]  = '{A_TMR,          0, 32'h0,        3'b010, 32'h0,         8'h00};
    vecs[2]  = '{A_STS,          0, 32'h0,        3'b010, 32'h0,         8'h00};
    vecs[3]  = '{32'h10,         1, 32'h11223344, 3'b010, 32'h0,         8'h00};
    vecs[4]  = '{32'h12,         1, 32'hFFFFFFAB, 3'b000, 32'h11223344,  8'h00};
    vecs[5]  = '{32'h10,         0, 32'h0,        3'b010, 32'h11AB3344,  8'h00};
    vecs[6]  = '{32'h22,         1, 32'h0000BEEF, 3'b001, 32'h0,         8'h00};
    vecs[7]  = '{32'h21,         1, 32'h00001234, 3'b001, 32'hBEEF0000,  8'h00};
    vecs[8]  = '{32'h20,         0, 32'h0,        3'b010, 32'hBEEF0000,  8'h00};
    vecs[9]  = '{A_STS,          0, 32'h0,        3'b010, 32'h2,         8'h00};
    vecs[10] = '{A_STS,          1, 32'h2,        3'b010, 32'h2,         8'h00};
    vecs[11] = '{A_STS,          0, 32'h0,        3'b010, 32'h0,         8'h00};
    vecs[12] = '{A_GPO,          1, 32'h5A,       3'b010, 32'h0,         8'h00};
    vecs[13] = '{A_GPO,          0, 32'h0,        3'b010, 32'h5A,        8'h5A};
    vecs[14] = '{A_GPO,          1, 32'hFF,       3'b000, 32'h5A,        8'h5A};
    vecs[15] = '{A_STS,          0, 32'h0,        3'b010, 32'h2,         8'h5A};
    vecs[16] = '{32'h4000_0000,  1, 32'hDEADBEEF, 3'b010, 32'h0,         8'h5A};
    vecs[17] = '{A_STS,          0, 32'h0,        3'b010, 32'h2,         8'h5A};
    vecs[18] = '{BASE + 32'h14,  1, 32'h77,       3'b010, 32'h0,         8'h5A};
    vecs[19] = '{BASE + 32'h14,  0, 32'h0,        3'b010, 32'h0,         8'h5A};
    vecs[20] = '{A_STS,          1, 32'h2,        3'b010, 32'h2,         8'h5A};
    vecs[21] = '{32'h10,         1, 32'h0,        3'b011, 32'h11AB3344,  8'h5A};
    vecs[22] = '{A_STS,          0, 32'h0,        3'b010, 32'h2,         8'h5A};
    vecs[23] = '{32'h10,         0, 32'h0,        3'b010, 32'h11AB3344,  8'h5A};
    vecs[24] = '{32'h11,         1, 32'h0,        3'b010, 32'h11AB3344,  8'h5A};
    vecs[25] = '{32'h10,         0, 32'h0,        3'b010, 32'h11AB3344,  8'h5A};
    vecs[26] = '{A_CTL,          1, 32'hFFFFFFFC, 3'b010, 32'h0,         8'h5A};
    vecs[27] = '{A_CTL,          0, 32'h0,        3'b010, 32'h0,         8'h5A};

    // Reset, then hold outputs low while reset is asserted.
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
    cyc(1'b0, A_GPO, 1'b1, 32'hFF, 3'b010);
    check("rst_gpio", act_gpio, 8'h00);
    check("rst_irq", act_irq, 1'b0);

    // Give the RAM words the random phase reads a known value.
    for (int w = 0; w < 64; w++) sw(w * 4, 32'h0);
    sw(32'hFF8, 32'h0);
    sw(32'hFFC, 32'h0);

    for (int i = 0; i < 28; i++) begin
      cyc(1'b1, vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].f3);
      check($sformatf("vec%0d_rd", i), act_rd, vecs[i].e_rd);
      check($sformatf("vec%0d_gpio", i), act_gpio, vecs[i].e_gpio);
      check($sformatf("vec%0d_irq", i), act_irq, 1'b0);
    end

    // Timer compare and interrupt.
    sw(A_STS, 32'h3);
    sw(A_CMP, 32'h5);
    sw(A_CTL, 32'h3);
    for (int k = 0; k <= 5; k++) begin
      rd(A_TMR);
      check($sformatf("tmr_count%0d", k), act_rd, k);
      check($sformatf("tmr_irq_low%0d", k), act_irq, 1'b0);
    end
    rd(A_STS);
    check("match_set", act_rd, 32'h1);
    check("irq_rise", act_irq, 1'b1);
    sw(A_STS, 32'h1);
    check("irq_before_w1c", act_irq, 1'b1);
    rd(A_STS);
    check("match_cleared", act_rd, 32'h0);
    check("irq_cleared", act_irq, 1'b0);
    sw(A_TMR, 32'h5);
    rd(A_TMR);
    check("tmr_reload5", act_rd, 32'h5);
    rd(A_STS);
    check("match_reset", act_rd, 32'h1);
    check("irq_reset", act_irq, 1'b1);
    sw(A_CTL, 32'h1);
    rd(A_STS);
    check("irq_masked", act_irq, 1'b0);

    // Wrap and write-beats-increment.
    sw(A_TMR, 32'hFFFF_FFFE);
    rd(A_TMR); check("wrap_fe", act_rd, 32'hFFFF_FFFE);
    rd(A_TMR); check("wrap_ff", act_rd, 32'hFFFF_FFFF);
    rd(A_TMR); check("wrap_00", act_rd, 32'h0);
    rd(A_TMR); check("wrap_01", act_rd, 32'h1);
    sw(A_TMR, 32'h100);
    rd(A_TMR); check("tmr_wr_wins", act_rd, 32'h100);
    rd(A_TMR); check("tmr_after_wr", act_rd, 32'h101);

    // Reset mid-count with a compare hit pending on the reset edge.
    sw(A_GPO, 32'hFF);
    sw(A_CTL, 32'h3);
    sw(A_CMP, 32'h200);
    sw(A_TMR, 32'h200);
    cyc(1'b0, 32'h10, 1'b1, 32'h0, 3'b010);
    check("rst2_gpio", act_gpio, 8'h00);
    check("rst2_irq", act_irq, 1'b0);
    rd(A_TMR); check("rst2_timer", act_rd, 32'h0);
    rd(A_CMP); check("rst2_cmp", act_rd, 32'hFFFF_FFFF);
    rd(A_STS); check("rst2_status", act_rd, 32'h0);
    check("rst2_irq_after", act_irq, 1'b0);
    rd(A_GPO); check("rst2_gporeg", act_rd, 32'h0);
    check("rst2_gpio_after", act_gpio, 8'h00);
    rd(A_CTL); check("rst2_ctrl", act_rd, 32'h0);
    rd(32'h10); check("rst2_ram_kept", act_rd, 32'h11AB3344);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 49) != 0);
      rwe = $urandom_range(0, 1);
      rf3 = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ra = $urandom_range(0, 255);
        4, 5, 6, 7: ra = BASE + $urandom_range(0, 31);
        8:          ra = 32'h4000_0000 | $urandom_range(0, 65535);
        default:    ra = 32'hFF8 + $urandom_range(0, 15);
      endcase
      cyc(rr, ra, rwe, ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15), rf3);
      check("rnd_rd", act_rd, exp_rd);
      check("rnd_gpio", act_gpio, exp_gpio);
      check("rnd_irq", act_irq, exp_irq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
